// File: rtl/cod16x4_arb_pkg.sv
// Shared constants and state encoding for the 16-to-4 request encoder/arbiter.
package cod16x4_arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/cod16x4_arb_if.sv
// Request/grant bundle between the requesters, the arbiter and the memory controller.
interface cod16x4_arb_if;
  import cod16x4_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             idx_ready;
  logic [N_REQ-1:0] grant;
  logic             busy;

  modport master (input req, idx_ready, output idx, idx_valid, grant, busy);
  modport slave  (output req, idx_ready, input idx, idx_valid, grant, busy);
endinterface

// File: rtl/cod16x4_arb_enc16x4_prio.sv
// Combinational priority encoder: first set request scanning upward from start, wrapping.
module enc16x4_prio
  import cod16x4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] pos;

  // Rotate so that bit 'start' lands at position 0, then find the lowest set bit.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[i[IDX_W-1:0] + start];
    end
  end

  always_comb begin
    pos = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i[IDX_W-1:0];
    end
  end

  // Adding start back maps the rotated position to the real requester index (mod 16).
  assign idx = pos + start;
  assign any = |req;
endmodule

// File: rtl/cod16x4_arb.sv
// Registered 16-to-4 arbiter with valid/ready handshake, round-robin or fixed priority.
//   state   | meaning
//   ST_IDLE | no grant outstanding; a nonzero req is encoded and loaded on the next edge
//   ST_HOLD | grant presented; idx/grant frozen until idx_ready is seen
module cod16x4_arb
  import cod16x4_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  cod16x4_arb_if.master  bus
);
  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win;
  logic             any;
  logic             load;
  logic             accept;

  assign start = ROUND_ROBIN ? ptr : '0;

  enc16x4_prio u_enc (
    .req   (bus.req),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (load)   idx_q <= win;
      if (accept) ptr   <= idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          load      = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.idx_ready) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = (state == ST_HOLD);
  assign bus.busy      = (state == ST_HOLD);
  assign bus.grant     = (state == ST_HOLD) ? (N_REQ'(1) << idx_q) : '0;
endmodule
